// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg
//  Description : Shared types for the fetch/decode instruction queue:
//                pre-decode class encoding, exception-bit positions and the
//                queue entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    // Entry fields are carried at these widths. Narrower top-level
    // ADDR_WIDTH / INST_WIDTH values are zero-extended into them.
    localparam int c_addr_w = 32;
    localparam int c_inst_w = 32;

    // Exception vector layout: {break, syscall, ine}
    localparam int c_exc_w       = 3;
    localparam int c_exc_ine     = 0;
    localparam int c_exc_syscall = 1;
    localparam int c_exc_break   = 2;

    typedef enum logic [3:0] {
        CLS_ALU3R   = 4'd0,
        CLS_UI5     = 4'd1,
        CLS_SI12    = 4'd2,
        CLS_SI20    = 4'd3,
        CLS_CSR     = 4'd4,
        CLS_RDCNT   = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JUMP    = 4'd7,
        CLS_LOAD    = 4'd8,
        CLS_STORE   = 4'd9,
        CLS_BREAK   = 4'd10,
        CLS_SYSCALL = 4'd11,
        CLS_INVALID = 4'd15
    } inst_class_e;

    typedef struct packed {
        logic [c_addr_w-1:0] pc;
        logic [c_inst_w-1:0] inst;
        logic                pred_taken;
        logic [c_addr_w-1:0] pred_target;
        inst_class_e         cls;
        logic [c_exc_w-1:0]  exc;
    } fq_entry_t;

    function automatic logic [c_exc_w-1:0] exc_from_class(input inst_class_e cls);
        logic [c_exc_w-1:0] v_exc;
        v_exc              = '0;
        v_exc[c_exc_break]   = (cls == CLS_BREAK);
        v_exc[c_exc_syscall] = (cls == CLS_SYSCALL);
        v_exc[c_exc_ine]     = (cls == CLS_INVALID);
        return v_exc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_queue_predecode.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_queue_predecode
//  Description : Combinational pre-decode of one instruction into its class
//                and exception flags. The first matching pattern wins.
//  Ports       : i_inst   - instruction word
//                o_class  - inst_class_e encoding
//                o_except - {break, syscall, ine}
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue_predecode
    import fetch_queue_pkg::*;
(
    input  wire logic [c_inst_w-1:0] i_inst,
    output logic      [3:0]          o_class,
    output logic      [c_exc_w-1:0]  o_except
);

    inst_class_e w_class;

    always_comb begin
        w_class = CLS_INVALID;
        if (i_inst[31:15] == 17'h00054)
            w_class = CLS_BREAK;
        else if (i_inst[31:15] == 17'h00056)
            w_class = CLS_SYSCALL;
        else if (i_inst[31:11] == 21'b000000000000000001100)
            w_class = CLS_RDCNT;
        else if ((i_inst[31:22] == 10'd0) && (i_inst[21] || i_inst[20]))
            w_class = CLS_ALU3R;
        else if ((i_inst[31:20] == 12'h004) && (i_inst[17:15] == 3'b001))
            w_class = CLS_UI5;
        else if (i_inst[31:25] == 7'b0000001)
            w_class = CLS_SI12;
        else if (i_inst[31:24] == 8'h04)
            w_class = CLS_CSR;
        else if (i_inst[31:28] == 4'b0001)
            w_class = CLS_SI20;
        else if ((i_inst[31:30] == 2'b01) && (i_inst[29:26] >= 4'b0110) && (i_inst[29:26] <= 4'b1011))
            w_class = CLS_BRANCH;
        else if ((i_inst[31:30] == 2'b01) && (i_inst[29:26] >= 4'b0011) && (i_inst[29:26] <= 4'b0101))
            w_class = CLS_JUMP;
        else if ((i_inst[31:29] == 3'b001) && (i_inst[28:24] == 5'b01001))
            w_class = CLS_STORE;
        else if (i_inst[31:29] == 3'b001)
            w_class = CLS_LOAD;
    end

    assign o_class  = w_class;
    assign o_except = exc_from_class(w_class);

endmodule
`default_nettype wire

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_queue
//  Description : Circular instruction buffer between fetch and a multi-issue
//                decode stage. Up to IN_WIDTH instructions are pre-decoded
//                and enqueued per cycle; the OUT_WIDTH oldest entries are
//                presented, and the consumer pops up to OUT_WIDTH of them.
//                flush empties the queue and overrides enqueue and pop.
//  Build macro : FETCH_BYPASS_EN - when defined, an enqueue into an empty
//                queue is shown on out_* in the same cycle; bypassed entries
//                popped that cycle are never written into storage.
//  Ports       : clk, rst_n (async active-low), flush
//                in_valid/in_count/in_pc/in_inst/in_pred_taken/
//                in_pred_target - fetch bundle, slot 0 first
//                in_ready       - room for a full bundle (registered count)
//                out_valid      - thermometer of presented entries
//                out_pc/out_inst/out_pred_taken/out_pred_target/out_class/
//                out_except     - presented entries, slot 0 oldest
//                out_pop        - entries consumed this cycle
//                count          - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int IN_WIDTH   = 2,
    parameter int OUT_WIDTH  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  wire logic                             clk,
    input  wire logic                             rst_n,
    input  wire logic                             flush,
    input  wire logic                             in_valid,
    input  wire logic [$clog2(IN_WIDTH+1)-1:0]    in_count,
    input  wire logic [IN_WIDTH*ADDR_WIDTH-1:0]   in_pc,
    input  wire logic [IN_WIDTH*INST_WIDTH-1:0]   in_inst,
    input  wire logic [IN_WIDTH-1:0]              in_pred_taken,
    input  wire logic [IN_WIDTH*ADDR_WIDTH-1:0]   in_pred_target,
    output logic                                  in_ready,
    output logic      [OUT_WIDTH-1:0]             out_valid,
    output logic      [OUT_WIDTH*ADDR_WIDTH-1:0]  out_pc,
    output logic      [OUT_WIDTH*INST_WIDTH-1:0]  out_inst,
    output logic      [OUT_WIDTH-1:0]             out_pred_taken,
    output logic      [OUT_WIDTH*ADDR_WIDTH-1:0]  out_pred_target,
    output logic      [OUT_WIDTH*4-1:0]           out_class,
    output logic      [OUT_WIDTH*3-1:0]           out_except,
    input  wire logic [$clog2(OUT_WIDTH+1)-1:0]   out_pop,
    output logic      [$clog2(DEPTH+1)-1:0]       count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam int c_in_w  = $clog2(IN_WIDTH+1);
    localparam int c_pop_w = $clog2(OUT_WIDTH+1);

    fq_entry_t           r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;

    fq_entry_t           w_in_entry  [IN_WIDTH];
    fq_entry_t           w_out_entry [OUT_WIDTH];
    logic                w_enq;
    logic                w_bypass;
    logic [c_in_w-1:0]   w_in_cnt;
    logic [c_pop_w-1:0]  w_pop_eff;
    int                  w_avail;
    int                  w_skip;
    logic [IN_WIDTH-1:0] w_wr_en;
    logic [c_ptr_w-1:0]  w_wr_idx [IN_WIDTH];
    logic [c_ptr_w-1:0]  w_head_inc;

    // ------------------------------------------------------------------
    // Pre-decode at the enqueue port
    // ------------------------------------------------------------------
    for (genvar g = 0; g < IN_WIDTH; g++) begin : g_predecode
        logic [3:0]         w_cls;
        logic [c_exc_w-1:0] w_exc;

        fetch_decode_queue_predecode u_predecode (
            .i_inst   (c_inst_w'(in_inst[g*INST_WIDTH +: INST_WIDTH])),
            .o_class  (w_cls),
            .o_except (w_exc)
        );

        assign w_in_entry[g] = '{
            pc:          c_addr_w'(in_pc[g*ADDR_WIDTH +: ADDR_WIDTH]),
            inst:        c_inst_w'(in_inst[g*INST_WIDTH +: INST_WIDTH]),
            pred_taken:  in_pred_taken[g],
            pred_target: c_addr_w'(in_pred_target[g*ADDR_WIDTH +: ADDR_WIDTH]),
            cls:         inst_class_e'(w_cls),
            exc:         w_exc
        };
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready = (r_count <= c_cnt_w'(DEPTH - IN_WIDTH));
    assign w_enq    = in_valid && in_ready && !flush;
    assign w_in_cnt = w_enq ? in_count : '0;
    assign count    = r_count;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_enq && (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Presented entries and clamped pop. Without bypass this depends only
    // on registered count, so out_pop never reaches out_* or in_ready.
    always_comb begin
        w_avail = w_bypass ? int'(in_count) : int'(r_count);
        if (w_avail > OUT_WIDTH)
            w_avail = OUT_WIDTH;
        w_pop_eff = (int'(out_pop) > w_avail) ? c_pop_w'(w_avail) : out_pop;
        for (int i = 0; i < OUT_WIDTH; i++)
            out_valid[i] = (i < w_avail);
    end

    // Bypassed slots consumed in the same cycle are skipped, so the slots
    // that remain are packed down starting at tail.
    always_comb begin
        w_skip = w_bypass ? int'(w_pop_eff) : 0;
        for (int j = 0; j < IN_WIDTH; j++) begin
            w_wr_en[j]  = w_enq && (j < int'(in_count)) && (j >= w_skip);
            w_wr_idx[j] = r_tail + c_ptr_w'(j) - c_ptr_w'(w_skip);
        end
    end

    // A bypass pop consumes incoming slots, not stored ones.
    assign w_head_inc = w_bypass ? '0 : c_ptr_w'(w_pop_eff);

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_head_inc;
            r_tail  <= r_tail + c_ptr_w'(w_in_cnt) - c_ptr_w'(w_skip);
            r_count <= r_count + c_cnt_w'(w_in_cnt) - c_cnt_w'(w_pop_eff);
        end
    end

    // Storage holds no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        for (int j = 0; j < IN_WIDTH; j++) begin
            if (w_wr_en[j])
                r_mem[w_wr_idx[j]] <= w_in_entry[j];
        end
    end

    // ------------------------------------------------------------------
    // Output slots, slot 0 oldest
    // ------------------------------------------------------------------
    for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_out
        logic [c_ptr_w-1:0] w_rd_idx;
        assign w_rd_idx = r_head + c_ptr_w'(g);

        if (g < IN_WIDTH) begin : g_bypass_mux
            assign w_out_entry[g] = w_bypass ? w_in_entry[g] : r_mem[w_rd_idx];
        end else begin : g_mem_only
            assign w_out_entry[g] = r_mem[w_rd_idx];
        end

        assign out_pc[g*ADDR_WIDTH +: ADDR_WIDTH]          = ADDR_WIDTH'(w_out_entry[g].pc);
        assign out_inst[g*INST_WIDTH +: INST_WIDTH]        = INST_WIDTH'(w_out_entry[g].inst);
        assign out_pred_taken[g]                           = w_out_entry[g].pred_taken;
        assign out_pred_target[g*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(w_out_entry[g].pred_target);
        assign out_class[g*4 +: 4]                         = w_out_entry[g].cls;
        assign out_except[g*3 +: 3]                        = w_out_entry[g].exc;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(in_valid && (in_count > c_in_w'(IN_WIDTH))))
                else $error("in_count exceeds IN_WIDTH");
            assert (int'(out_pop) <= w_avail)
                else $error("out_pop exceeds presented entries");
        end
    end
`endif

endmodule
`default_nettype wire
